// File: rtl/gb_cpu_m_cycle_sequencer.sv
// M-cycle sequencer: steps through the decoder's per-M-cycle control words and owns instruction
// boundaries, CB mode and IME. Optional interrupt dispatch: GB_CPU_SEQ_IRQ_DISPATCH_EN.
package gb_cpu_seq_pkg;

  localparam int unsigned SchedSteps = 6;

  typedef enum logic [1:0] {
    ADDR_BUS_REG16,
    ADDR_BUS_HIGH_C,
    ADDR_BUS_HIGH_Z,
    ADDR_BUS_ALU
  } addr_bus_source_e;

  typedef enum logic [3:0] {
    REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_A, REG_F,
    REG_IR, REG_SP, REG_PC, REG_Z, REG_W, REG_BC, REG_DE, REG_HL
  } reg_e;

  typedef enum logic [1:0] {
    IDU_NOP,
    IDU_INC,
    IDU_DEC,
    IDU_PASS
  } idu_opcode_e;

  typedef struct packed {
    addr_bus_source_e addr_bus_source;
    reg_e             addr_bus_source_r16;
    reg_e             data_bus_i_destination;
    logic             data_bus_o_wren;
    idu_opcode_e      idu_opcode;
    reg_e             idu_operand;
    reg_e             idu_destination;
    logic             idu_wren;
    logic [3:0]       alu_opcode;
    logic             alu_wren;
    logic             regfile_wren;
    logic             cc_check;
    logic             enable_interrupts;
    logic             disable_interrupts;
    logic             rst_cmd;
    logic             bit_cmd;
  } instruction_controls_t;

  typedef struct packed {
    logic [2:0]                                   m_cycles;
    logic [1:0]                                   condition;
    logic                                         cb_prefix_next;
    instruction_controls_t [SchedSteps-1:0]       instruction_controls;
  } schedule_t;

endpackage

module gb_cpu_m_cycle_sequencer
  import gb_cpu_seq_pkg::*;
#(
  parameter int unsigned MAX_STEPS = SchedSteps
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  schedule_t             schedule_i,
  input  logic                  cc_met_i,
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
  input  logic                  irq_pending_i,
  output logic                  irq_dispatch_o,
`endif
  output instruction_controls_t controls_o,
  output logic [2:0]            step_o,
  output logic                  instr_start_o,
  output logic                  instr_done_o,
  output logic                  cb_mode_o,
  output logic                  ime_o
);

  localparam int unsigned      StepW  = $clog2(MAX_STEPS);
  localparam logic [StepW-1:0] MaxIdx = StepW'(MAX_STEPS - 1);

  typedef enum logic {StBoot, StRun} state_e;

  state_e           stateQ, stateD;
  logic [StepW-1:0] stepQ, stepD;
  schedule_t        schedQ, schedD;
  logic             cbModeQ, cbModeD;
  logic             imeQ, imeD;
  logic             eiPendQ, eiPendD;
  logic             eiArmQ, eiArmD;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
  logic             irqDispQ, irqDispD;
`endif

  schedule_t             activeSched;
  logic [StepW-1:0]      lastIdx;
  instruction_controls_t selWord, lastWord, execWord;
  logic                  inRun, stepValid, earlyTerm, finalCycle;
  logic                  unusedCondition;

  function automatic instruction_controls_t fetchWord();
    instruction_controls_t w;
    w                        = '0;
    w.addr_bus_source        = ADDR_BUS_REG16;
    w.addr_bus_source_r16    = REG_PC;
    w.data_bus_i_destination = REG_IR;
    w.idu_opcode             = IDU_INC;
    w.idu_operand            = REG_PC;
    w.idu_destination        = REG_PC;
    w.idu_wren               = 1'b1;
    return w;
  endfunction

  // Step 0 decodes straight from the decoder; later steps replay the latched copy.
  assign inRun       = (stateQ == StRun);
  assign activeSched = (stepQ == '0) ? schedule_i : schedQ;
  assign lastIdx     = (32'(activeSched.m_cycles) > MAX_STEPS - 1) ? MaxIdx
                                                                   : StepW'(activeSched.m_cycles);
  assign stepValid   = inRun && (stepQ <= lastIdx);
  assign selWord     = activeSched.instruction_controls[stepQ];
  assign lastWord    = activeSched.instruction_controls[lastIdx];
  assign earlyTerm   = stepValid && selWord.cc_check && !cc_met_i && (stepQ != lastIdx);
  assign finalCycle  = stepValid && ((stepQ == lastIdx) || earlyTerm);
  assign execWord    = earlyTerm ? lastWord : selWord;

  // The condition code is evaluated upstream; cc_met_i carries the result.
  assign unusedCondition = ^activeSched.condition;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= StBoot;
      stepQ    <= '0;
      cbModeQ  <= 1'b0;
      imeQ     <= 1'b0;
      eiPendQ  <= 1'b0;
      eiArmQ   <= 1'b0;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
      irqDispQ <= 1'b0;
`endif
    end else begin
      stateQ   <= stateD;
      stepQ    <= stepD;
      cbModeQ  <= cbModeD;
      imeQ     <= imeD;
      eiPendQ  <= eiPendD;
      eiArmQ   <= eiArmD;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
      irqDispQ <= irqDispD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    schedQ <= schedD;
  end

  always_comb begin
    stateD   = stateQ;
    stepD    = '0;
    schedD   = schedQ;
    cbModeD  = cbModeQ;
    imeD     = imeQ;
    eiPendD  = eiPendQ;
    eiArmD   = eiArmQ;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
    irqDispD = 1'b0;
`endif
    if (stateQ == StBoot) begin
      stateD = StRun;
    end else if (stepValid) begin
      if (stepQ == '0) begin
        schedD = schedule_i;
      end
      if (finalCycle) begin
        cbModeD = activeSched.cb_prefix_next;
        // An EI from the previous instruction takes effect as this one ends.
        if (eiArmQ) begin
          imeD = 1'b1;
        end
        eiArmD  = eiPendQ || execWord.enable_interrupts;
        eiPendD = 1'b0;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
        if (imeQ && irq_pending_i && !activeSched.cb_prefix_next) begin
          irqDispD = 1'b1;
          imeD     = 1'b0;
          eiPendD  = 1'b0;
          eiArmD   = 1'b0;
        end
`endif
      end else begin
        stepD = stepQ + 1'b1;
        if (execWord.enable_interrupts) begin
          eiPendD = 1'b1;
        end
      end
      if (execWord.disable_interrupts) begin
        imeD    = 1'b0;
        eiPendD = 1'b0;
        eiArmD  = 1'b0;
      end
    end
  end

  // An out-of-range step fetches like BOOT and restarts at step 0.
  always_comb begin
    controls_o    = fetchWord();
    instr_start_o = 1'b0;
    instr_done_o  = 1'b1;
    if (stepValid) begin
      controls_o    = execWord;
      instr_start_o = (stepQ == '0);
      instr_done_o  = finalCycle;
    end
  end

  assign step_o    = 3'(stepQ);
  assign cb_mode_o = cbModeQ;
  assign ime_o     = imeQ;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
  assign irq_dispatch_o = irqDispQ;
`endif

endmodule

// File: tb/tb_gb_cpu_m_cycle_sequencer.sv
// Randomized self-checking bench for gb_cpu_m_cycle_sequencer against an instruction-level model.
module tb_gb_cpu_m_cycle_sequencer;
  import gb_cpu_seq_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  schedule_t             schedule_i;
  logic                  cc_met_i;
  instruction_controls_t controls_o;
  logic [2:0]            step_o;
  logic                  instr_start_o, instr_done_o, cb_mode_o, ime_o;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
  logic                  irq_pending_i, irq_dispatch_o;
`endif

  int   nChecks = 0;
  int   nFails = 0;
  logic imeModel, cbModel;
  int   instrIdx;
  int   eiQ[$];  // instruction indices at whose end IME turns on

  always #5 clk = ~clk;

  gb_cpu_m_cycle_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .schedule_i    (schedule_i),
    .cc_met_i      (cc_met_i),
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
    .irq_pending_i (irq_pending_i),
    .irq_dispatch_o(irq_dispatch_o),
`endif
    .controls_o    (controls_o),
    .step_o        (step_o),
    .instr_start_o (instr_start_o),
    .instr_done_o  (instr_done_o),
    .cb_mode_o     (cb_mode_o),
    .ime_o         (ime_o)
  );

  task automatic checkVal(input string tag, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic instruction_controls_t expFetch();
    instruction_controls_t w;
    w                        = '0;
    w.addr_bus_source        = ADDR_BUS_REG16;
    w.addr_bus_source_r16    = REG_PC;
    w.data_bus_i_destination = REG_IR;
    w.idu_opcode             = IDU_INC;
    w.idu_operand            = REG_PC;
    w.idu_destination        = REG_PC;
    w.idu_wren               = 1'b1;
    return w;
  endfunction

  function automatic schedule_t mkSched(input logic [2:0] m, input logic cb);
    schedule_t s;
    s                = '0;
    s.m_cycles       = m;
    s.cb_prefix_next = cb;
    for (int k = 0; k < SchedSteps; k++) s.instruction_controls[k].alu_opcode = 4'(k + 1);
    return s;
  endfunction

  function automatic instruction_controls_t randWord();
    logic [63:0]           r;
    instruction_controls_t w;
    r                   = {$urandom, $urandom};
    w                   = r[$bits(instruction_controls_t)-1:0];
    w.cc_check          = ($urandom_range(0, 2) == 0);
    w.enable_interrupts = ($urandom_range(0, 6) == 0);
    w.disable_interrupts = ($urandom_range(0, 9) == 0);
    return w;
  endfunction

  function automatic schedule_t randSched(input bit garbage);
    schedule_t s;
    s.m_cycles       = garbage ? 3'($urandom) : 3'($urandom_range(0, 5));
    s.condition      = 2'($urandom);
    s.cb_prefix_next = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < SchedSteps; k++) s.instruction_controls[k] = randWord();
    return s;
  endfunction

  // Runs one instruction; the decoder output is only meaningful in its first cycle.
  task automatic runInstr(input schedule_t s, input logic [5:0] cc);
    int                    last;
    bit                    early, fin;
    instruction_controls_t w, expW;
    int                    keep[$];
    last = int'(s.m_cycles);
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      schedule_i = (k == 0) ? s : randSched(1'b1);
      cc_met_i   = cc[k];
      #1;
      w     = s.instruction_controls[k];
      early = (k != last) && w.cc_check && !cc[k];
      fin   = early || (k == last);
      expW  = early ? s.instruction_controls[last] : w;
      checkVal("controls", 128'(controls_o), 128'(expW));
      checkVal("step", 128'(step_o), 128'(k));
      checkVal("start", 128'(instr_start_o), 128'(k == 0));
      checkVal("done", 128'(instr_done_o), 128'(fin));
      checkVal("cb_mode", 128'(cb_mode_o), 128'(cbModel));
      checkVal("ime", 128'(ime_o), 128'(imeModel));
      if (expW.disable_interrupts) begin
        imeModel = 1'b0;
        eiQ.delete();
      end else if (expW.enable_interrupts) begin
        eiQ.push_back(instrIdx + 1);
      end
      if (fin) begin
        keep = {};
        foreach (eiQ[i]) begin
          if (eiQ[i] == instrIdx) imeModel = 1'b1;
          else if (eiQ[i] > instrIdx) keep.push_back(eiQ[i]);
        end
        eiQ      = keep;
        cbModel  = s.cb_prefix_next;
        instrIdx++;
        break;
      end
    end
  endtask

  task automatic checkBootOutputs(input string tag);
    checkVal({tag, "_controls"}, 128'(controls_o), 128'(expFetch()));
    checkVal({tag, "_done"}, 128'(instr_done_o), 128'(1'b1));
    checkVal({tag, "_start"}, 128'(instr_start_o), 128'(1'b0));
    checkVal({tag, "_step"}, 128'(step_o), 128'(0));
    checkVal({tag, "_cb"}, 128'(cb_mode_o), 128'(1'b0));
    checkVal({tag, "_ime"}, 128'(ime_o), 128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    schedule_t s, nop, eiS, diS;
    schedule_i = '0;
    cc_met_i   = 1'b0;
`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
    irq_pending_i = 1'b0;
`endif
    imeModel = 1'b0;
    cbModel  = 1'b0;
    instrIdx = 0;
    nop      = mkSched(3'd0, 1'b0);
    eiS      = mkSched(3'd0, 1'b0);
    eiS.instruction_controls[0].enable_interrupts = 1'b1;
    diS      = mkSched(3'd0, 1'b0);
    diS.instruction_controls[0].disable_interrupts = 1'b1;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkBootOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkBootOutputs("boot");

    // ADD A,B: single-cycle, ALU write each cycle
    s = mkSched(3'd0, 1'b0);
    s.instruction_controls[0].alu_wren = 1'b1;
    repeat (3) runInstr(s, 6'h3f);

    // JR cc: taken and not taken, plus cc_check at step 0 and on the final step
    s = mkSched(3'd2, 1'b0);
    s.instruction_controls[1].cc_check = 1'b1;
    runInstr(s, 6'b000000);
    runInstr(s, 6'b111111);
    s = mkSched(3'd3, 1'b0);
    s.instruction_controls[0].cc_check = 1'b1;
    runInstr(s, 6'b000000);
    s = mkSched(3'd1, 1'b0);
    s.instruction_controls[1].cc_check = 1'b1;
    runInstr(s, 6'b000000);

    // CB prefix affects exactly the following instruction
    runInstr(mkSched(3'd0, 1'b1), 6'h00);
    runInstr(nop, 6'h00);
    runInstr(nop, 6'h00);

    // EI delay across a 2-cycle instruction, then EI;DI cancels
    runInstr(eiS, 6'h00);
    runInstr(mkSched(3'd1, 1'b0), 6'h00);
    runInstr(nop, 6'h00);
    runInstr(diS, 6'h00);
    runInstr(eiS, 6'h00);
    runInstr(diS, 6'h00);
    runInstr(nop, 6'h00);
    runInstr(nop, 6'h00);

`ifdef GB_CPU_SEQ_IRQ_DISPATCH_EN
    runInstr(eiS, 6'h00);
    runInstr(nop, 6'h00);
    runInstr(nop, 6'h00);
    irq_pending_i = 1'b1;
    runInstr(nop, 6'h00);
    @(posedge clk);
    #1;
    irq_pending_i = 1'b0;
    schedule_i    = nop;
    #1;
    imeModel = 1'b0;
    eiQ.delete();
    checkVal("irq_dispatch_pulse", 128'(irq_dispatch_o), 128'(1'b1));
    checkVal("irq_ime_cleared", 128'(ime_o), 128'(1'b0));
    checkVal("irq_start", 128'(instr_start_o), 128'(1'b1));
    cbModel = 1'b0;
    instrIdx++;
    runInstr(nop, 6'h00);
    checkVal("irq_dispatch_end", 128'(irq_dispatch_o), 128'(1'b0));
`endif

    // Asynchronous reset at step 1 of a 3-step instruction with IME and CB mode set
    runInstr(eiS, 6'h00);
    runInstr(nop, 6'h00);
    runInstr(nop, 6'h00);
    runInstr(mkSched(3'd0, 1'b1), 6'h00);
    s = mkSched(3'd2, 1'b0);
    @(posedge clk);
    #1;
    schedule_i = s;
    cc_met_i   = 1'b1;
    #1;
    checkVal("pre_rst_start", 128'(instr_start_o), 128'(1'b1));
    @(posedge clk);
    #1;
    schedule_i = randSched(1'b1);
    #1;
    checkVal("pre_rst_step", 128'(step_o), 128'(1));
    checkVal("pre_rst_cb", 128'(cb_mode_o), 128'(1'b1));
    checkVal("pre_rst_ime", 128'(ime_o), 128'(imeModel));
    rst_n = 1'b0;
    #1;
    checkBootOutputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkBootOutputs("post_rst_boot");
    imeModel = 1'b0;
    cbModel  = 1'b0;
    eiQ.delete();
    instrIdx++;

    for (int n = 0; n < 250; n++) begin
      runInstr(randSched(1'b0), 6'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
